sram_wb_bridge: RTL and testbench

- Wishbone classic slave that translates bus cycles into single accesses on the RW port (port 0) of the 32x256 1rw1r OpenRAM macro.
- Sits directly upstream of the macro: drives csb0/web0/wmask0/addr0/din0, captures dout0, returns ack/data to the bus.
- Absorbs the macro's timing: inputs are registered at posedge, the array is accessed at negedge, and dout0 goes X shortly after the next posedge.

---
 rtl/sram_wb_bridge.sv | 113 +++++++++++
 tb/tb_sram_wb_bridge.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_wb_bridge.sv
// Wishbone classic slave serving single accesses on port 0 (RW) of the 32x256 1rw1r OpenRAM macro.
// Optional macro SRAM_WB_ERR_EN: error-acknowledge out-of-window addresses and zero-select reads.
module sram_wb_bridge #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_WMASKS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [NUM_WMASKS-1:0] wb_sel_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  sram_clk0,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t state;
    logic   abort;
    logic   req;
    logic   unused_bits;

    assign sram_clk0   = clk;
    assign req         = wb_cyc_i & wb_stb_i;
    assign unused_bits = ^{wb_adr_i[1:0], wb_adr_i[31:ADDR_WIDTH+2], BASE_ADDR};

`ifdef SRAM_WB_ERR_EN
    logic addr_miss;
    assign addr_miss = (wb_adr_i[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            abort       <= 1'b0;
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            wb_dat_o    <= '0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        abort  <= 1'b0;
                        busy_o <= 1'b1;
`ifdef SRAM_WB_ERR_EN
                        if (addr_miss || (!wb_we_i && wb_sel_i == '0)) begin
                            wb_err_o <= 1'b1;
                            state    <= ACK;
                        end else
`endif
                        if (wb_we_i && wb_sel_i == '0) begin
                            wb_ack_o <= 1'b1;
                            state    <= ACK;
                        end else begin
                            sram_addr0  <= wb_adr_i[ADDR_WIDTH+1:2];
                            sram_din0   <= wb_dat_i;
                            sram_web0   <= ~wb_we_i;
                            sram_wmask0 <= wb_we_i ? wb_sel_i : '0;
                            sram_csb0   <= 1'b0;
                            state       <= ISSUE;
                        end
                    end
                end
                // Macro latches the request at this edge; release select so it is low one cycle only.
                ISSUE: begin
                    sram_csb0 <= 1'b1;
                    sram_web0 <= 1'b1;
                    if (sram_web0) begin
                        abort <= ~wb_cyc_i;
                        state <= WAIT;
                    end else begin
                        wb_ack_o <= wb_cyc_i;
                        state    <= ACK;
                    end
                end
                // dout0 is valid here and turns X shortly after this edge.
                WAIT: begin
                    wb_dat_o <= sram_dout0;
                    wb_ack_o <= wb_cyc_i & ~abort;
                    state    <= ACK;
                end
                ACK: begin
                    wb_ack_o <= 1'b0;
                    wb_err_o <= 1'b0;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_wb_bridge.sv
// Randomized self-checking bench for sram_wb_bridge with a behavioural macro and a word-array reference.
// Works with or without SRAM_WB_ERR_EN defined.
module tb_sram_wb_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = 4'h0;
    logic [31:0] wb_adr_i = 32'h0, wb_dat_i = 32'h0;
    logic        wb_ack_o, wb_err_o, busy_o;
    logic [31:0] wb_dat_o;
    logic        sram_clk0, sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0 = 32'h0;

    always #5 clk = ~clk;

    sram_wb_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_dat_o(wb_dat_o),
        .sram_clk0(sram_clk0), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
        .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_dout0(sram_dout0), .busy_o(busy_o)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          csb_cnt = 0;
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic        prev_low = 1'b0;
    logic        pend = 1'b0, p_we = 1'b0;
    logic [7:0]  p_a = 8'h0;
    logic [3:0]  p_m = 4'h0;
    logic [31:0] p_d = 32'h0;
    logic [7:0]  last_addr = 8'h0;
    logic        last_web = 1'b1;
    logic [3:0]  last_mask = 4'h0;
    logic [31:0] last_din = 32'h0;
    logic [31:0] last_rdat = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural macro: latches at posedge, accesses the array at the following negedge,
    // and returns garbage on dout0 shortly after each posedge.
    always @(posedge sram_clk0) begin
        #2;
        sram_dout0 = $urandom;
        @(negedge sram_clk0);
        if (pend) begin
            if (p_we) begin
                for (int b = 0; b < 4; b++)
                    if (p_m[b]) mem[p_a][8*b +: 8] = p_d[8*b +: 8];
            end
        end
        #1;
        if (pend && !p_we) sram_dout0 = mem[p_a];
        pend = !sram_csb0 && rst_n;
        if (pend) begin
            csb_cnt++;
            check("csb_consecutive", {31'b0, prev_low}, 32'd0);
            p_we = !sram_web0;
            p_a  = sram_addr0;
            p_m  = sram_wmask0;
            p_d  = sram_din0;
            last_addr = sram_addr0;
            last_web  = sram_web0;
            last_mask = sram_wmask0;
            last_din  = sram_din0;
        end
        prev_low = pend;
    end

    task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, input int drop_in);
        logic        is_err, acc, got_err;
        logic [7:0]  idx;
        int          exp_lat, lat, base, drop;
        idx  = adr[9:2];
        drop = drop_in;
`ifdef SRAM_WB_ERR_EN
        is_err = (adr[31:10] != BASE[31:10]) || (!we && sel == 4'h0);
`else
        is_err = 1'b0;
`endif
        acc     = !is_err && !(we && sel == 4'h0);
        exp_lat = is_err ? 1 : (we ? (acc ? 2 : 1) : 3);
        if (!acc) drop = 0;
        if (drop > 0) exp_lat = 0;
        lat     = 0;
        got_err = 1'b0;

        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
        base = csb_cnt;
        @(posedge clk);
        for (int n = 1; n <= 6; n++) begin
            #1;
            if (n == 1) check("busy_high", {31'b0, busy_o}, 32'd1);
            if (wb_ack_o || wb_err_o) begin
                lat       = n;
                got_err   = wb_err_o;
                last_rdat = wb_dat_o;
                break;
            end
            if (n == drop) begin
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
            end
            @(posedge clk);
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
            check("ack_one_cycle", {30'b0, wb_ack_o, wb_err_o}, 32'd0);
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after", {31'b0, busy_o}, 32'd0);

        check("latency", lat, exp_lat);
        if (lat > 0) check("err_vs_ack", {31'b0, got_err}, {31'b0, is_err});
        check("csb_accesses", csb_cnt - base, acc ? 32'd1 : 32'd0);
        if (acc) begin
            check("macro_addr", {24'b0, last_addr}, {24'b0, idx});
            check("macro_web", {31'b0, last_web}, {31'b0, !we});
            check("macro_wmask", {28'b0, last_mask}, we ? {28'b0, sel} : 32'd0);
            if (we) begin
                check("macro_din", last_din, dat);
                for (int b = 0; b < 4; b++)
                    if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
            end else if (drop == 0) begin
                check("read_data", last_rdat, ref_mem[idx]);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_csb", {31'b0, sram_csb0}, 32'd1);
        check("rst_web", {31'b0, sram_web0}, 32'd1);
        check("rst_wmask", {28'b0, sram_wmask0}, 32'd0);
        check("rst_addr", {24'b0, sram_addr0}, 32'd0);
        check("rst_din", sram_din0, 32'd0);
        check("rst_ack_err", {30'b0, wb_ack_o, wb_err_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        bus_xfer(1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, 0);
        bus_xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 0);
        check("tp_read_beef", last_rdat, 32'hDEAD_BEEF);
        bus_xfer(1'b1, 32'h3000_0012, 4'b0101, 32'h1122_3344, 0);
        bus_xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 0);
        check("tp_merge", last_rdat, 32'hDE22_BE44);
        bus_xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 2);
        bus_xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 0);
        bus_xfer(1'b1, 32'h3000_0020, 4'hF, 32'hCAFE_F00D, 1);
        bus_xfer(1'b0, 32'h3000_0020, 4'hF, 32'h0, 0);
        bus_xfer(1'b1, 32'h3000_0010, 4'h0, 32'h5555_5555, 0);
        bus_xfer(1'b0, 32'h3000_0400, 4'hF, 32'h0, 0);
        bus_xfer(1'b0, 32'h3000_0010, 4'h0, 32'h0, 0);

        // Reset while the read sits in WAIT.
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = 32'h3000_0010; wb_sel_i = 4'hF;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_csb", {31'b0, sram_csb0}, 32'd1);
        check("midrst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("midrst_busy", {31'b0, busy_o}, 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus_xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 0);
        check("post_rst_read", last_rdat, 32'hDE22_BE44);

        for (int t = 0; t < 150; t++) begin
            logic        we;
            logic [31:0] adr;
            logic [3:0]  sel;
            int          drop;
            we  = $urandom_range(1, 0) == 1;
            adr = BASE | ($urandom & 32'h0000_03FF);
            if ($urandom_range(3, 0) == 0) adr = adr ^ ({$urandom} & 32'hFFFF_FC00);
            sel = ($urandom_range(5, 0) == 0) ? 4'h0 : 4'($urandom);
            drop = 0;
            if ($urandom_range(7, 0) == 0) drop = we ? 1 : 2;
            bus_xfer(we, adr, sel, $urandom, drop);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
